// File: rtl/sub_sat_pkg.sv
// Shared helpers for the saturating subtractor pipeline: range limits and clip function.
// Functions work on a fixed wide signed type so any operand width below MAX_W can reuse them.
package sub_sat_pkg;

    localparam int SAT_COUNT_W = 16;
    localparam int MAX_W       = 32;

    typedef logic signed [MAX_W:0] wide_t;

    typedef struct packed {
        logic [MAX_W-1:0] diff;
        logic             sat_pos;
        logic             sat_neg;
    } clip_t;

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Callers keep only the low w bits of diff; the limits are exact in those bits.
    function automatic clip_t sat_clip(input wide_t full, input int w);
        wide_t mx;
        wide_t mn;
        clip_t r;
        mx        = sat_max(w);
        mn        = sat_min(w);
        r.diff    = full[MAX_W-1:0];
        r.sat_pos = 1'b0;
        r.sat_neg = 1'b0;
        if (full > mx) begin
            r.diff    = mx[MAX_W-1:0];
            r.sat_pos = 1'b1;
        end else if (full < mn) begin
            r.diff    = mn[MAX_W-1:0];
            r.sat_neg = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_sat_stage.sv
// Generic valid/ready register slice: holds one item, loads when empty or when downstream drains it.
module sub_sat_stage #(
    parameter int DW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          down_ready,
    output logic          load,
    output logic          valid,
    output logic [DW-1:0] data
);

    assign load = ~valid | down_ready;

    // Data only moves with a real item so an idle slot keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= in_valid;
            if (in_valid) data <= in_data;
        end
    end

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready signed subtractor clipping a - b into the W-bit range.
// Optional saturation event counter enabled by defining SUB_SAT_COUNT_EN.
module signed_sub_with_saturation_pipe
    import sub_sat_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         sat_pos,
    output logic         sat_neg
`ifdef SUB_SAT_COUNT_EN
    ,
    output logic [SAT_COUNT_W-1:0] sat_count
`endif
);

    // W must stay below MAX_W so the clip helper has headroom for the W+1 bit difference.
    logic [W:0]   full_c;
    logic         s1_load;
    logic         s1_valid;
    logic [W:0]   s1_data;
    logic         s2_load;
    logic [W+1:0] s2_in;
    logic [W+1:0] s2_data;
    wide_t        full_w;
    clip_t        clip;
    logic         unused_clip_hi;

    assign full_c = {a[W-1], a} - {b[W-1], b};

    sub_sat_stage #(.DW(W + 1)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (full_c),
        .down_ready (s2_load),
        .load       (s1_load),
        .valid      (s1_valid),
        .data       (s1_data)
    );

    assign full_w         = wide_t'($signed(s1_data));
    assign clip           = sat_clip(full_w, W);
    assign s2_in          = {clip.diff[W-1:0], clip.sat_pos, clip.sat_neg};
    assign unused_clip_hi = ^clip.diff[MAX_W-1:W];

    sub_sat_stage #(.DW(W + 2)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s1_valid),
        .in_data    (s2_in),
        .down_ready (out_ready),
        .load       (s2_load),
        .valid      (out_valid),
        .data       (s2_data)
    );

    assign in_ready = rst_n & s1_load;
    assign diff     = s2_data[W+1:2];
    assign sat_pos  = s2_data[1];
    assign sat_neg  = s2_data[0];

`ifdef SUB_SAT_COUNT_EN
    typedef logic [SAT_COUNT_W-1:0] cnt_t;
    cnt_t cnt;

    // Counts saturated results as they leave; pins at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (out_valid & out_ready & (sat_pos | sat_neg) & ~&cnt) begin
            cnt <= cnt + cnt_t'(1);
        end
    end

    assign sat_count = cnt;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Randomized and directed bench for the saturating subtractor pipeline with a queue-based reference.
module tb_signed_sub_with_saturation_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         sat_pos;
    logic         sat_neg;
`ifdef SUB_SAT_COUNT_EN
    logic [15:0]  sat_count;
    logic [15:0]  exp_cnt = '0;
`endif

    int vectors = 0;
    int errors  = 0;

    logic [W+1:0] exp_q[$];
    logic         stalled = 1'b0;
    logic [W+1:0] held = '0;

    signed_sub_with_saturation_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .sat_pos   (sat_pos),
        .sat_neg   (sat_neg)
`ifdef SUB_SAT_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer difference, then clip to the W-bit signed range.
    function automatic logic [W+1:0] ref_sub(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int d;
        int mx;
        int mn;
        mx = (1 << (W - 1)) - 1;
        mn = -(1 << (W - 1));
        d  = int'($signed(xa)) - int'($signed(xb));
        if (d > mx) return {W'(mx), 2'b10};
        if (d < mn) return {W'(mn), 2'b01};
        return {W'(d), 2'b00};
    endfunction

    // Scoreboard: observe transfers that will complete on the coming rising edge.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            stalled = 1'b0;
`ifdef SUB_SAT_COUNT_EN
            exp_cnt = '0;
`endif
        end else begin
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({diff, sat_pos, sat_neg}), 32'(held));
            end
            chk("flags_excl", 32'(sat_pos & sat_neg), 32'd0);
`ifdef SUB_SAT_COUNT_EN
            chk("sat_count", 32'(sat_count), 32'(exp_cnt));
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 32'({diff, sat_pos, sat_neg}), 32'(e));
                end
`ifdef SUB_SAT_COUNT_EN
                if ((sat_pos | sat_neg) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
            stalled = out_valid && !out_ready;
            held    = {diff, sat_pos, sat_neg};
            if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb);
        int n;
        n = 0;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Sends into an empty pipe with out_ready=1 and checks the 2-cycle latency and result.
    task automatic send_check(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                              input logic [W+1:0] exp);
        send(xa, xb);
        @(negedge clk);
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_out"}, 32'({out_valid, diff, sat_pos, sat_neg}), 32'({1'b1, exp}));
        tick();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    logic [W-1:0] bp_a[4] = '{4'h1, 4'hD, 4'h7, 4'h8};
    logic [W-1:0] bp_b[4] = '{4'h2, 4'h4, 4'hF, 4'h3};

    initial begin
        int idx;
        int acc;
        int ins;
        int outs;
        logic rdy_ok;
        logic [5:0] ov;

        repeat (2) tick();
        @(negedge clk);
        chk("reset_state", 32'({out_valid, diff, sat_pos, sat_neg, in_ready}), 32'd0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;

        send_check("basic_neg", 4'h3, 4'h5, {4'hE, 2'b00});
        send_check("basic_pos", 4'h3, 4'hB, {4'h7, 2'b10});
        send_check("c0_m8", 4'h0, 4'h8, {4'h7, 2'b10});
        send_check("m8_1", 4'h8, 4'h1, {4'h8, 2'b01});
        send_check("m8_m8", 4'h8, 4'h8, {4'h0, 2'b00});
        send_check("c7_m8", 4'h7, 4'h8, {4'h7, 2'b10});
        send_check("m8_7", 4'h8, 4'h7, {4'h8, 2'b01});

        // Backpressure: two items fill the pipe, then the stream drains in order.
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        in_valid = 1'b1;
        a = bp_a[0];
        b = bp_b[0];
        repeat (6) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                acc++;
                idx++;
            end
            tick();
            a = bp_a[idx];
            b = bp_b[idx];
        end
        chk("bp_accepts", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ov[k] = out_valid;
            if (in_valid && in_ready) idx++;
            tick();
            if (idx < 4) begin
                a = bp_a[idx];
                b = bp_b[idx];
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_flow", 32'(ov), 32'h0F);

        // Full pipe with simultaneous input and output transfers.
        out_ready = 1'b0;
        send(W'($urandom), W'($urandom));
        send(W'($urandom), W'($urandom));
        out_ready = 1'b1;
        in_valid = 1'b1;
        ins = 0;
        outs = 0;
        rdy_ok = 1'b1;
        repeat (10) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (!in_ready) rdy_ok = 1'b0;
            if (in_valid && in_ready) ins++;
            if (out_valid && out_ready) outs++;
            tick();
        end
        in_valid = 1'b0;
        chk("sim_ins", 32'(ins), 32'd10);
        chk("sim_outs", 32'(outs), 32'd10);
        chk("sim_ready", 32'(rdy_ok), 32'd1);
        repeat (3) tick();

        // Reset with two items in flight.
        out_ready = 1'b0;
        send(4'h7, 4'h8);
        send(4'h2, 4'h1);
        reset_pulse();
        @(negedge clk);
        chk("rst_mid", 32'({out_valid, diff, sat_pos, sat_neg}), 32'd0);
        tick();
        out_ready = 1'b1;
        send_check("post_rst", 4'h1, 4'h1, {4'h0, 2'b00});

        // Random traffic with random backpressure.
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef SUB_SAT_COUNT_EN
        reset_pulse();
        send_check("cnt_s1", 4'h8, 4'h1, {4'h8, 2'b01});
        send_check("cnt_n1", 4'h2, 4'h1, {4'h1, 2'b00});
        send_check("cnt_s2", 4'h0, 4'h8, {4'h7, 2'b10});
        send_check("cnt_n2", 4'h8, 4'h8, {4'h0, 2'b00});
        send_check("cnt_s3", 4'h7, 4'h8, {4'h7, 2'b10});
        @(negedge clk);
        chk("cnt_three", 32'(sat_count), 32'd3);
        tick();
        in_valid = 1'b1;
        a = 4'h8;
        b = 4'h1;
        repeat (65540) tick();
        in_valid = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("cnt_stick", 32'(sat_count), 32'hFFFF);
        tick();
        send_check("cnt_more", 4'h8, 4'h1, {4'h8, 2'b01});
        @(negedge clk);
        chk("cnt_stick2", 32'(sat_count), 32'hFFFF);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
